// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared FSM states, limits and round-robin search helper for edge_event_arbiter
package edge_arb_pkg;
    typedef enum logic {IDLE, OFFER} state_t;
    localparam int MAX_N = 16;
    localparam int MAX_CW = 4;
    typedef struct packed {
        logic found;
        logic [MAX_CW-1:0] idx;
    } pick_t;
    // First set bit of pend[0..n-1] scanning from ptr upward with wrap
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] pend, input logic [MAX_CW-1:0] ptr, input int n);
        pick_t r;
        int j;
        r = '0;
        for (int k = 0; k < MAX_N; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !r.found && pend[j]) begin
                r.found = 1'b1;
                r.idx = MAX_CW'(j);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/dual_edge_cell.sv
// dual_edge_cell: per-channel dual-edge detector with pending event, polarity and sticky overflow
module dual_edge_cell (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic clr_pending,
    input  logic ovf_clr,
    output logic pending,
    output logic pol,
    output logic overflow
);
    logic prev_q, pend_q, pol_q, ovf_q;
    logic pend_d, pol_d, ovf_d, edge_seen;
    always_comb begin
        edge_seen = in != prev_q;
        pend_d = edge_seen | (pend_q & ~clr_pending);
        pol_d = edge_seen ? in : pol_q;
        // A new edge only loses data when the old event is neither taken nor being granted now
        ovf_d = (edge_seen & pend_q & ~clr_pending) | (ovf_q & ~ovf_clr);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            pol_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            prev_q <= in;
            pend_q <= pend_d;
            pol_q <= pol_d;
            ovf_q <= ovf_d;
        end
    end
    assign pending = pend_q;
    assign pol = pol_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: collects dual-edge events from N inputs and drains them round-robin
// over a single valid/ready channel, one event per cycle.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  in,
    input  logic          evt_ready,
    input  logic          ovf_clr,
    output logic          evt_valid,
    output logic [CW-1:0] evt_ch,
    output logic          evt_rise,
    output logic [N-1:0]  overflow
);
    state_t state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d, ch_q, ch_d;
    logic rise_q, rise_d, grant;
    logic [N-1:0] pending, pol, clr;
    pick_t pk;
    for (genvar i = 0; i < N; i++) begin : g_cell
        dual_edge_cell u_cell (
            .clk(clk),
            .reset(reset),
            .in(in[i]),
            .clr_pending(clr[i]),
            .ovf_clr(ovf_clr),
            .pending(pending[i]),
            .pol(pol[i]),
            .overflow(overflow[i])
        );
    end
    assign pk = rr_pick(MAX_N'(pending), MAX_CW'(ptr_q), N);
    always_comb begin
        // The output slot is free in IDLE, or in OFFER when the current event transfers
        grant = pk.found && (state_q == IDLE || evt_ready);
        clr = grant ? N'(1) << pk.idx : '0;
        ch_d = grant ? CW'(pk.idx) : ch_q;
        rise_d = grant ? pol[CW'(pk.idx)] : rise_q;
        ptr_d = !grant ? ptr_q : (pk.idx == MAX_CW'(N - 1)) ? '0 : CW'(pk.idx + 1'b1);
        state_d = grant ? OFFER : (state_q == OFFER && evt_ready) ? IDLE : state_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            ch_q <= '0;
            rise_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            ch_q <= ch_d;
            rise_q <= rise_d;
        end
    end
    assign evt_valid = state_q == OFFER;
    assign evt_ch = ch_q;
    assign evt_rise = rise_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed self-checking bench for edge_event_arbiter (N=4)
module tb_edge_event_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] in = '0;
    logic evt_ready = 1'b0;
    logic ovf_clr = 1'b0;
    logic evt_valid, evt_rise;
    logic [1:0] evt_ch;
    logic [3:0] overflow;
    int vectors = 0;
    int fails = 0;
    int nevt;
    logic [1:0] last_ch;
    logic last_rise;

    edge_event_arbiter #(.N(4)) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .evt_ready(evt_ready),
        .ovf_clr(ovf_clr),
        .evt_valid(evt_valid),
        .evt_ch(evt_ch),
        .evt_rise(evt_rise),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_offer(input string tag, input logic [1:0] ch, input logic rise);
        chk({tag, ".valid"}, 32'(evt_valid), 32'd1);
        chk({tag, ".ch"}, 32'(evt_ch), 32'(ch));
        chk({tag, ".rise"}, 32'(evt_rise), 32'(rise));
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst.valid", 32'(evt_valid), 32'd0);
        chk("rst.ch", 32'(evt_ch), 32'd0);
        chk("rst.rise", 32'(evt_rise), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // single rise on ch2, two edges latency, one-cycle offer
        evt_ready = 1'b1;
        in[2] = 1'b1;
        tick();
        chk("t1.pend_only", 32'(evt_valid), 32'd0);
        tick();
        chk_offer("t1.offer", 2'd2, 1'b1);
        tick();
        chk("t1.done", 32'(evt_valid), 32'd0);
        chk("t1.ovf", 32'(overflow), 32'd0);

        // prime in[1] high and drain it (ptr 3 -> 2)
        in[1] = 1'b1;
        tick();
        tick();
        chk_offer("t2.prime", 2'd1, 1'b1);
        tick();
        chk("t2.prime_done", 32'(evt_valid), 32'd0);

        // backpressure
        evt_ready = 1'b0;
        in[1] = 1'b0;
        tick();
        tick();
        tick();
        in[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_offer("t2.hold", 2'd1, 1'b0);
        end
        evt_ready = 1'b1;
        tick();
        chk_offer("t2.b2b", 2'd3, 1'b1);
        tick();
        chk("t2.done", 32'(evt_valid), 32'd0);

        // fairness: all four toggle, ptr = 0; in 1100 -> 0011
        in = 4'b0011;
        tick();
        tick();
        chk_offer("t3.g0", 2'd0, 1'b1);
        tick();
        chk_offer("t3.g1", 2'd1, 1'b1);
        tick();
        chk_offer("t3.g2", 2'd2, 1'b0);
        tick();
        chk_offer("t3.g3", 2'd3, 1'b0);
        tick();
        chk("t3.done", 32'(evt_valid), 32'd0);

        // grant ch1 so ptr = 2, then ch0 and ch2 together
        in[1] = 1'b0;
        tick();
        tick();
        chk_offer("t4.ch1", 2'd1, 1'b0);
        tick();
        in[0] = 1'b0;
        in[2] = 1'b1;
        tick();
        tick();
        chk_offer("t4.first", 2'd2, 1'b1);
        tick();
        chk_offer("t4.second", 2'd0, 1'b0);
        tick();
        chk("t4.done", 32'(evt_valid), 32'd0);

        // overflow: get ch0 onto the output as a fall, held by backpressure
        in[0] = 1'b1;
        tick();
        tick();
        tick();
        evt_ready = 1'b0;
        in[0] = 1'b0;
        tick();
        tick();
        chk_offer("t5.offer", 2'd0, 1'b0);
        in[0] = 1'b1;
        tick();
        tick();
        chk("t5.no_ovf", 32'(overflow), 32'd0);
        in[0] = 1'b0;
        tick();
        tick();
        in[0] = 1'b1;
        tick();
        tick();
        chk("t5.ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5.clr", 32'(overflow), 32'd0);
        in[0] = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5.set_wins", 32'(overflow), 32'd1);
        in[0] = 1'b1;
        tick();
        chk_offer("t5.still_held", 2'd0, 1'b0);
        evt_ready = 1'b1;
        tick();
        chk_offer("t5.newest", 2'd0, 1'b1);
        tick();
        chk("t5.done", 32'(evt_valid), 32'd0);

        // reset mid-offer with two pending (ptr = 1, in = 0101)
        evt_ready = 1'b0;
        in[1] = 1'b1;
        tick();
        tick();
        chk_offer("t6.offer", 2'd1, 1'b1);
        in[2] = 1'b0;
        in[3] = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t6.valid", 32'(evt_valid), 32'd0);
        chk("t6.ch", 32'(evt_ch), 32'd0);
        chk("t6.rise", 32'(evt_rise), 32'd0);
        chk("t6.ovf", 32'(overflow), 32'd0);
        in = '0;
        evt_ready = 1'b1;
        tick();
        #2 reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t6.quiet", 32'(evt_valid), 32'd0);
        end

        // input held high through reset plus a sub-cycle glitch
        reset = 1'b1;
        in[0] = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        in[1] = 1'b1;
        #2 in[1] = 1'b0;
        nevt = 0;
        last_ch = '0;
        last_rise = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (evt_valid) begin
                nevt++;
                last_ch = evt_ch;
                last_rise = evt_rise;
            end
        end
        chk("t7.count", 32'(nevt), 32'd1);
        chk("t7.ch", 32'(last_ch), 32'd0);
        chk("t7.rise", 32'(last_rise), 32'd1);
        chk("t7.ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel dual-edge event collector and round-robin scheduler. Each of N single-bit synchronous inputs has its own dual-edge detector. Detected edges are latched as pending events. One shared output channel drains the events one at a time under a valid/ready handshake, with fair round-robin ordering. The block sits between the FSM edge-detection datapath and any single consumer (UART logger, counter bank) that services events serially.

## Interface
- `N`, default 4, number of input channels (2..16).
- `CW`, default `$clog2(N)`, width of the channel index.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in`  in  N  monitored signals, synchronous to `clk` (the source synchronizes them).
- `evt_ready`  in  1  consumer accepts the offered event.
- `ovf_clr`  in  1  clears all overflow flags.
- `evt_valid`  out  1  event offered.
- `evt_ch`  out  CW  channel index of the offered event.
- `evt_rise`  out  1  1 = rising edge, 0 = falling edge.
- `overflow`  out  N  sticky per-channel flag: an event was lost.

## Operation
- Per channel i: `prev[i]` holds the registered last sample. An edge exists when `in[i] != prev[i]`, and its polarity is `in[i]`. `prev` updates every cycle.
- Edge on channel i at a clock edge:
  - If `pending[i]` is 0, or channel i is being granted or consumed that cycle: set `pending[i]` to 1 and `pol[i]` to the new polarity. No overflow.
  - Otherwise: keep `pending[i]` at 1, overwrite `pol[i]` with the newest polarity, and set `overflow[i]`.
- Round-robin pointer `ptr` (CW bits) gives the search order `ptr, ptr+1, …, N-1, 0, …` (wraps). After a grant of channel g, `ptr` becomes `g+1` mod N.
- FSM with states IDLE and OFFER, defined in the package.
  - IDLE:
    - `evt_valid` = 0.
    - If any pending bit is set, grant the first pending channel in search order. Load `evt_ch` and `evt_rise` from it, clear its pending bit (unless a new edge arrives that cycle), and move to OFFER.
  - OFFER:
    - `evt_valid` = 1. `evt_ch` and `evt_rise` are held stable while `evt_ready` = 0.
    - When `evt_ready` = 1 and other events are pending, grant the next channel in the same cycle and stay in OFFER (back-to-back, one event per cycle).
    - When `evt_ready` = 1 and nothing is pending, return to IDLE.
- `overflow` is sticky. `ovf_clr` clears all bits. A set and a clear on the same bit in the same cycle: set wins.
- `prev` resets to 0. An input held high through reset therefore produces exactly one rise event after reset deasserts.
- Pulses that start and end between two clock edges are not seen. This is by design.

## Timing
- Reset is asynchronous. While `reset` = 1:
  - `evt_valid`, `evt_ch`, `evt_rise`, `overflow`, `pending`, `pol`, `prev` and `ptr` are all 0.
  - State is IDLE.
  - Reset mid-offer drops the offered event and all pending events.
- Latency, with `in[i]` changing between clock edges k-1 and k:
  - `pending[i]` is set at edge k.
  - `evt_valid` rises after edge k+1 if the output is free.
- Handshake: transfer happens on a rising edge with `evt_valid && evt_ready`. `evt_valid` never drops without a transfer, except on reset.
- Throughput: 1 event per cycle under continuous `evt_ready`, with no bubble between grants.
- `evt_ready` is ignored while `evt_valid` = 0.

## Structure
- Package `edge_arb_pkg`:
  - `state_t` enum {IDLE, OFFER}.
  - Max-N constant.
  - `function rr_pick(pending, ptr)` returning found flag and index.
- Sub-module `dual_edge_cell`, instantiated N times. Per channel it holds `prev`, `pending`, `pol` and the overflow flag. Inputs are `clk`, `reset`, `in`, `clr_pending`, `ovf_clr`. Outputs are `pending`, `pol`, `overflow`.
- The top level holds the FSM, `ptr`, and the output registers.

## Test plan
- Reset, then a `in[2]` 0→1 edge with `evt_ready` = 1: `evt_valid` = 1 for exactly one cycle, two edges after the input change, with `evt_ch` = 2 and `evt_rise` = 1. `overflow` = 0.
- Backpressure: `evt_ready` = 0, `in[1]` 1→0, then `in[3]` 0→1 three cycles later. Offer of ch1/fall is held stable for 5 cycles. Raise `evt_ready` for 2 cycles: ch1/fall then ch3/rise on consecutive cycles, then `evt_valid` = 0.
- Fairness:
  - All 4 inputs toggle in the same cycle with `evt_ready` = 1: grants in order 0, 1, 2, 3 on consecutive cycles.
  - After a grant of ch1 (`ptr` = 2), ch0 and ch2 edge together: order is 2, then 0.
- Overflow, with `evt_ready` = 0 and ch0 already offered:
  - ch0 rise, then fall, then rise, each 2 cycles apart. `overflow[0]` = 1 and the pending polarity is rise.
  - Pulse `ovf_clr`: `overflow` goes to 0.
  - `ovf_clr` in the same cycle as a new overflow: `overflow[0]` stays 1.
- Reset mid-operation: assert `reset` asynchronously, off-clock, while `evt_valid` = 1 with 2 events pending. All outputs go to 0 immediately. After deassert with inputs stable low, no events appear.
- `in[0]` held high through reset: exactly one ch0/rise event after reset deasserts. A sub-cycle glitch on `in[1]` between clock edges produces no event.
